div_clk_monitor: RTL and testbench

- Receive-side companion to the team's clock dividers.
- Takes a slow divided clock produced elsewhere in the design, synchronizes it into the iClkIN domain, and emits single-cycle rise and fall strobes.
- Measures the divided clock's period in iClkIN cycles and declares lock when the period is stable.
- Flags loss of lock on period change or on timeout, so downstream logic can use the strobes as clock enables instead of clocking on the divided clock directly.

---
 rtl/div_clk_monitor.sv | 144 ++++++++++++++
 tb/tb_div_clk_monitor.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/div_clk_monitor.sv
// Syncs a divided clock into iClkIN, emits rise/fall strobes, measures its period and tracks lock.
// Latency: strobes appear 3 iClkIN edges after the new iDivClk level; no backpressure (free-running).
module div_clk_monitor #(
    parameter int CNT_W    = 8,
    parameter int LOCK_CNT = 4,
    parameter int TOL      = 1,
    parameter int TIMEOUT  = 200
) (
    input  logic             iClkIN,
    input  logic             reset,
    input  logic             iDivClk,
    output logic             oRise,
    output logic             oFall,
    output logic [CNT_W-1:0] oPeriod,
    output logic             oLock,
    output logic             oLoss
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_FIRST  = 2'd1;
    localparam logic [1:0] ST_TRACK  = 2'd2;
    localparam logic [1:0] ST_LOCKED = 2'd3;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W:0]   TOL_W   = (CNT_W+1)'(TOL);
    localparam logic [3:0]       LOCK_N  = 4'(LOCK_CNT);

    logic             s1, s2, s3;
    logic [1:0]       state, state_n;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] ref_per, ref_per_n;
    logic [3:0]       match, match_n;
    logic             lock_entry;
    logic             loss_n;

    logic [CNT_W:0]   meas;
    logic [CNT_W:0]   diff;
    logic             in_tol;
    logic             timeout_hit;

    // Period of the cycle ending now; one bit wider so the difference never wraps.
    assign meas   = {1'b0, cnt} + {{CNT_W{1'b0}}, 1'b1};
    assign diff   = (meas >= {1'b0, ref_per}) ? (meas - {1'b0, ref_per})
                                              : ({1'b0, ref_per} - meas);
    assign in_tol = (diff <= TOL_W);

    // A rising strobe in the same cycle beats the timeout.
    assign timeout_hit = (state != ST_IDLE) && !oRise && (cnt == TO_LAST);

    always_ff @(posedge iClkIN) begin
        if (reset) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            s3    <= 1'b0;
            oRise <= 1'b0;
            oFall <= 1'b0;
        end else begin
            s1    <= iDivClk;
            s2    <= s1;
            s3    <= s2;
            oRise <= s2 & ~s3;
            oFall <= ~s2 & s3;
        end
    end

    always_ff @(posedge iClkIN) begin
        if (reset) begin
            cnt <= '0;
        end else if (oRise) begin
            cnt <= '0;
        end else if (cnt != CNT_MAX) begin
            cnt <= cnt + 1'b1;
        end
    end

    always_comb begin
        state_n    = state;
        ref_per_n  = ref_per;
        match_n    = match;
        lock_entry = 1'b0;
        loss_n     = 1'b0;
        if (oRise) begin
            case (state)
                ST_IDLE: begin
                    state_n = ST_FIRST;
                end
                ST_FIRST: begin
                    ref_per_n = meas[CNT_W-1:0];
                    match_n   = 4'd0;
                    state_n   = ST_TRACK;
                end
                ST_TRACK: begin
                    if (in_tol) begin
                        if (match + 4'd1 == LOCK_N) begin
                            state_n    = ST_LOCKED;
                            match_n    = 4'd0;
                            lock_entry = 1'b1;
                        end else begin
                            match_n = match + 4'd1;
                        end
                    end else begin
                        ref_per_n = meas[CNT_W-1:0];
                        match_n   = 4'd0;
                    end
                end
                default: begin
                    if (!in_tol) begin
                        state_n   = ST_TRACK;
                        ref_per_n = meas[CNT_W-1:0];
                        match_n   = 4'd0;
                        loss_n    = 1'b1;
                    end
                end
            endcase
        end else if (timeout_hit) begin
            state_n   = ST_IDLE;
            ref_per_n = '0;
            match_n   = 4'd0;
            loss_n    = (state == ST_LOCKED);
        end
    end

    always_ff @(posedge iClkIN) begin
        if (reset) begin
            state   <= ST_IDLE;
            ref_per <= '0;
            match   <= 4'd0;
            oPeriod <= '0;
            oLock   <= 1'b0;
            oLoss   <= 1'b0;
        end else begin
            state   <= state_n;
            ref_per <= ref_per_n;
            match   <= match_n;
            oLock   <= (state_n == ST_LOCKED);
            oLoss   <= loss_n;
            if (lock_entry) begin
                oPeriod <= ref_per;
            end
        end
    end

endmodule

// File: tb/tb_div_clk_monitor.sv
// Directed bench for div_clk_monitor: a default instance plus a CNT_W=4/TIMEOUT=15 instance for the saturation corner.
module tb_div_clk_monitor;

    localparam int TIMEOUT = 200;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       div_clk = 1'b0;
    logic       div_clk2 = 1'b0;

    logic       rise, fall, lock, loss;
    logic [7:0] period;
    logic       rise2, fall2, lock2, loss2;
    logic [3:0] period2;

    div_clk_monitor #(.CNT_W(8), .LOCK_CNT(4), .TOL(1), .TIMEOUT(TIMEOUT)) dut (
        .iClkIN(clk), .reset(reset), .iDivClk(div_clk),
        .oRise(rise), .oFall(fall), .oPeriod(period), .oLock(lock), .oLoss(loss)
    );

    div_clk_monitor #(.CNT_W(4), .LOCK_CNT(4), .TOL(1), .TIMEOUT(15)) dut_sat (
        .iClkIN(clk), .reset(reset), .iDivClk(div_clk2),
        .oRise(rise2), .oFall(fall2), .oPeriod(period2), .oLock(lock2), .oLoss(loss2)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    int   rise_q[$];
    int   fall_q[$];
    int   n_rise, n_fall, n_loss, loss_cyc, lock_cyc;
    logic loss_lock, prev_lock;
    logic [7:0] loss_per;

    int   rise2_q[$];
    int   n_loss2, lock2_cyc;
    logic prev_lock2, lock2_ever;

    task automatic clear_track();
        rise_q.delete();
        fall_q.delete();
        n_rise = 0; n_fall = 0; n_loss = 0; loss_cyc = -1; lock_cyc = -1;
        loss_lock = 1'bx; loss_per = 'x; prev_lock = lock;
        rise2_q.delete();
        n_loss2 = 0; lock2_cyc = -1; prev_lock2 = lock2; lock2_ever = 1'b0;
    endtask

    // Apply levels, advance one cycle, then sample outputs 1 time unit after the edge.
    task automatic clk1(input logic d, input logic d2);
        div_clk  = d;
        div_clk2 = d2;
        @(posedge clk);
        #1;
        cyc++;
        if (rise) begin n_rise++; rise_q.push_back(cyc); end
        if (fall) begin n_fall++; fall_q.push_back(cyc); end
        if (loss) begin
            n_loss++;
            if (n_loss == 1) begin loss_cyc = cyc; loss_lock = lock; loss_per = period; end
        end
        if (lock && !prev_lock && lock_cyc < 0) lock_cyc = cyc;
        prev_lock = lock;
        if (rise2) rise2_q.push_back(cyc);
        if (loss2) n_loss2++;
        if (lock2) lock2_ever = 1'b1;
        if (lock2 && !prev_lock2 && lock2_cyc < 0) lock2_cyc = cyc;
        prev_lock2 = lock2;
    endtask

    task automatic drive(input int n, input int hi, input bit sat);
        for (int i = 0; i < n; i++) begin
            if (sat) clk1(1'b0, i < hi);
            else     clk1(i < hi, 1'b0);
        end
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        for (int i = 0; i < n; i++) clk1(1'b0, 1'b0);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset(2);
        n_checks++;
        if ({rise, fall, lock, loss, period} !== 12'h0) begin
            n_fail++; $display("FAIL reset_outputs: got r%b f%b l%b x%b p%0d, want all 0", rise, fall, lock, loss, period);
        end
        n_checks++;
        if ({rise2, fall2, lock2, loss2, period2} !== 8'h0) begin
            n_fail++; $display("FAIL reset_outputs_sat: got r%b f%b l%b x%b p%0d, want all 0", rise2, fall2, lock2, loss2, period2);
        end
    endtask

    task automatic test_div4();
        int c0;
        clear_track();
        c0 = cyc;
        for (int p = 0; p < 8; p++) drive(4, 2, 1'b0);
        n_checks++;
        if (n_rise != 8 || rise_q[0] != c0 + 3 || rise_q[7] != c0 + 31) begin
            n_fail++; $display("FAIL div4_rise: got n=%0d first=%0d, want n=8 first=%0d", n_rise, (n_rise > 0) ? rise_q[0] - c0 : -1, 3);
        end
        n_checks++;
        if (n_fall != 7 || fall_q[0] != c0 + 5) begin
            n_fail++; $display("FAIL div4_fall: got n=%0d first=%0d, want n=7 first=5", n_fall, (n_fall > 0) ? fall_q[0] - c0 : -1);
        end
        n_checks++;
        if (lock_cyc != c0 + 24) begin
            n_fail++; $display("FAIL div4_lock_cycle: got %0d, want %0d", lock_cyc - c0, 24);
        end
        n_checks++;
        if (period !== 8'd4 || lock !== 1'b1 || n_loss != 0) begin
            n_fail++; $display("FAIL div4_state: got period=%0d lock=%b losses=%0d, want 4 1 0", period, lock, n_loss);
        end
    endtask

    task automatic test_period_change();
        clear_track();
        for (int p = 0; p < 6; p++) drive(16, 8, 1'b0);
        n_checks++;
        if (rise_q.size() < 6) begin
            n_fail++; $display("FAIL chg_rises: got %0d, want >= 6", rise_q.size());
        end else if (n_loss != 1 || loss_cyc != rise_q[1] + 1) begin
            n_fail++; $display("FAIL chg_loss: got n=%0d at %0d, want 1 at %0d", n_loss, loss_cyc, rise_q[1] + 1);
        end
        n_checks++;
        if (loss_lock !== 1'b0 || loss_per !== 8'd4) begin
            n_fail++; $display("FAIL chg_at_loss: got lock=%b period=%0d, want 0 4", loss_lock, loss_per);
        end
        n_checks++;
        if (rise_q.size() < 6 || lock_cyc != rise_q[5] + 1) begin
            n_fail++; $display("FAIL chg_relock_cycle: got %0d, want %0d", lock_cyc, (rise_q.size() >= 6) ? rise_q[5] + 1 : -1);
        end
        n_checks++;
        if (period !== 8'd16 || lock !== 1'b1) begin
            n_fail++; $display("FAIL chg_relock: got period=%0d lock=%b, want 16 1", period, lock);
        end
    endtask

    task automatic test_reset_mid_lock();
        clear_track();
        for (int p = 0; p < 8; p++) drive(4, 2, 1'b0);
        n_checks++;
        if (period !== 8'd4 || lock !== 1'b1) begin
            n_fail++; $display("FAIL mid_prelock: got period=%0d lock=%b, want 4 1", period, lock);
        end
        clear_track();
        reset = 1'b1;
        clk1(1'b0, 1'b0);
        reset = 1'b0;
        n_checks++;
        if ({rise, fall, lock, loss, period} !== 12'h0) begin
            n_fail++; $display("FAIL mid_reset_outputs: got r%b f%b l%b x%b p%0d, want all 0", rise, fall, lock, loss, period);
        end
        for (int p = 0; p < 8; p++) drive(4, 2, 1'b0);
        n_checks++;
        if (n_loss != 0 || rise_q.size() < 6 || lock_cyc != rise_q[5] + 1 || period !== 8'd4) begin
            n_fail++; $display("FAIL mid_reacquire: got losses=%0d lock_cyc=%0d period=%0d, want 0 6th-rise+1 4", n_loss, lock_cyc, period);
        end
    endtask

    task automatic test_tolerance();
        int lens[7] = '{8, 8, 9, 7, 8, 8, 8};
        do_reset(2);
        clear_track();
        drive(8, 4, 1'b0);
        for (int i = 0; i < 7; i++) drive(lens[i], 4, 1'b0);
        n_checks++;
        if (rise_q.size() != 8 || lock_cyc != rise_q[5] + 1) begin
            n_fail++; $display("FAIL tol_lock_cycle: got rises=%0d lock_cyc=%0d, want 8 and 6th-rise+1", rise_q.size(), lock_cyc);
        end
        n_checks++;
        if (period !== 8'd8 || lock !== 1'b1 || n_loss != 0) begin
            n_fail++; $display("FAIL tol_state: got period=%0d lock=%b losses=%0d, want 8 1 0", period, lock, n_loss);
        end
    endtask

    task automatic test_timeout_locked();
        int r;
        do_reset(2);
        clear_track();
        for (int p = 0; p < 8; p++) drive(4, 2, 1'b0);
        r = rise_q[$];
        clear_track();
        for (int i = 0; i < TIMEOUT + 20; i++) clk1(1'b0, 1'b0);
        // cnt reaches TIMEOUT-1 TIMEOUT edges after the strobe cycle; the exit is visible one edge later.
        n_checks++;
        if (n_loss != 1 || loss_cyc != r + TIMEOUT + 1) begin
            n_fail++; $display("FAIL to_lock_loss: got n=%0d at +%0d, want 1 at +%0d", n_loss, loss_cyc - r, TIMEOUT + 1);
        end
        n_checks++;
        if (lock !== 1'b0 || period !== 8'd4) begin
            n_fail++; $display("FAIL to_lock_state: got lock=%b period=%0d, want 0 4", lock, period);
        end
    endtask

    task automatic test_timeout_track();
        do_reset(2);
        clear_track();
        for (int p = 0; p < 3; p++) drive(4, 2, 1'b0);
        for (int i = 0; i < TIMEOUT + 30; i++) clk1(1'b0, 1'b0);
        n_checks++;
        if (n_loss != 0 || lock !== 1'b0) begin
            n_fail++; $display("FAIL to_track: got losses=%0d lock=%b, want 0 0", n_loss, lock);
        end
        // Back in IDLE, so a fresh lock needs the full six rises.
        clear_track();
        for (int p = 0; p < 8; p++) drive(4, 2, 1'b0);
        n_checks++;
        if (rise_q.size() < 6 || lock_cyc != rise_q[5] + 1) begin
            n_fail++; $display("FAIL to_track_relock: got lock_cyc=%0d, want %0d", lock_cyc, (rise_q.size() >= 6) ? rise_q[5] + 1 : -1);
        end
    endtask

    task automatic test_saturation();
        do_reset(2);
        clear_track();
        for (int p = 0; p < 8; p++) drive(15, 7, 1'b1);
        n_checks++;
        if (rise2_q.size() < 6 || lock2_cyc != rise2_q[5] + 1) begin
            n_fail++; $display("FAIL sat15_lock_cycle: got rises=%0d lock_cyc=%0d, want 6th-rise+1", rise2_q.size(), lock2_cyc);
        end
        n_checks++;
        if (period2 !== 4'd15 || lock2 !== 1'b1 || n_loss2 != 0) begin
            n_fail++; $display("FAIL sat15_state: got period=%0d lock=%b losses=%0d, want 15 1 0", period2, lock2, n_loss2);
        end
        do_reset(2);
        clear_track();
        for (int p = 0; p < 8; p++) drive(16, 8, 1'b1);
        n_checks++;
        if (rise2_q.size() != 8) begin
            n_fail++; $display("FAIL sat16_rises: got %0d, want 8", rise2_q.size());
        end
        n_checks++;
        if (lock2_ever !== 1'b0 || period2 !== 4'd0 || n_loss2 != 0) begin
            n_fail++; $display("FAIL sat16_nolock: got lock_seen=%b period=%0d losses=%0d, want 0 0 0", lock2_ever, period2, n_loss2);
        end
    endtask

    initial begin
        test_reset();
        test_div4();
        test_period_change();
        test_reset_mid_lock();
        test_tolerance();
        test_timeout_locked();
        test_timeout_track();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
